// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the memory.
// master = arbiter view (drives memory request and port completions); slave = environment view.
interface mem_bus_arbiter_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic [31:0] d_rdata;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    modport master (
        input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
        output i_ready, i_rdata, d_ready, d_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction/data) arbiter onto one memory bus, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate tie winners; otherwise ties go to the DATA_FIRST port.
module mem_bus_arbiter #(
    parameter int unsigned DATA_FIRST = 1
) (
    input  logic              clk,
    input  logic              resetn,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t      r_state;
    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic w_any_req;
    logic w_tie_d;
    logic w_grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;
    logic r_rr_armed;
    // Until the first tie is resolved the DATA_FIRST port wins, whatever last-grant says.
    assign w_tie_d = r_rr_armed ? ~r_last_d : (DATA_FIRST != 0);
`else
    assign w_tie_d = (DATA_FIRST != 0);
`endif

    assign w_any_req = bus.i_valid | bus.d_valid;
    assign w_grant_d = bus.d_valid & (~bus.i_valid | w_tie_d);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d    <= 1'b0;
            r_rr_armed  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_mem_valid <= 1'b1;
                        if (w_grant_d) begin
                            r_state     <= BUSY_D;
                            r_mem_addr  <= bus.d_addr;
                            r_mem_wdata <= bus.d_wdata;
                            r_mem_wstrb <= bus.d_wstrb;
                        end else begin
                            r_state     <= BUSY_I;
                            r_mem_addr  <= bus.i_addr;
                            r_mem_wdata <= '0;
                            r_mem_wstrb <= '0;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_d <= w_grant_d;
                        if (bus.i_valid && bus.d_valid) begin
                            r_rr_armed <= 1'b1;
                        end
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ready) begin
                        r_state     <= IDLE;
                        r_mem_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    // Completion strobes are gated by resetn so nothing completes in a reset cycle.
    assign bus.i_ready   = resetn & (r_state == BUSY_I) & bus.mem_ready;
    assign bus.d_ready   = resetn & (r_state == BUSY_D) & bus.mem_ready;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations (either ARB_ROUND_ROBIN_EN build).
module tb_mem_bus_arbiter;
    localparam int unsigned DF = 1;

    logic clk;
    logic resetn;
    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.DATA_FIRST(DF)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] memarr [logic [31:0]];
    int  mem_wait    = 1;
    bit  force_ready = 0;
    int  stall       = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (memarr.exists(a)) return memarr[a];
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        memarr[32'h10] = 32'h1234_5678;
        forever begin
            @(posedge clk);
            if (resetn && bus.mem_valid && bus.mem_ready && bus.mem_wstrb != 4'b0000) begin
                logic [31:0] w;
                w = rd(bus.mem_addr);
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                memarr[bus.mem_addr] = w;
            end
            #1;
            if (bus.mem_valid !== 1'b1) begin
                stall = 0;
                bus.mem_ready = force_ready;
            end else begin
                bus.mem_ready = (stall >= mem_wait);
                stall++;
            end
            bus.mem_rdata = rd(bus.mem_addr);
        end
    end

    // ---------------- requesters ----------------
    int  i_left = 0, d_left = 0;
    int  i_pulses = 0, d_pulses = 0;
    bit  d_auto = 1, d_manual = 0;
    logic [31:0] i_rdata_cap, d_rdata_cap, d_wdata_cap;
    logic [3:0]  d_wstrb_cap;
    bit  glog [$];

    initial begin
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.i_ready === 1'b1) begin
                i_pulses++;
                i_rdata_cap = bus.i_rdata;
                glog.push_back(1'b0);
                if (i_left > 0) i_left--;
            end
            if (bus.d_ready === 1'b1) begin
                d_pulses++;
                d_rdata_cap = bus.d_rdata;
                d_wdata_cap = bus.mem_wdata;
                d_wstrb_cap = bus.mem_wstrb;
                glog.push_back(1'b1);
                if (d_left > 0) d_left--;
            end
            bus.i_valid = (i_left > 0);
            bus.d_valid = d_auto ? (d_left > 0) : d_manual;
        end
    end

    // ---------------- transaction-level model ----------------
    bit          m_on = 0, m_busy = 0, m_d = 0, m_last_d = 0, m_armed = 0;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    always @(posedge clk) begin
        if (!resetn) begin
            m_on = 1; m_busy = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
            m_last_d = 0; m_armed = 0;
        end else if (m_on) begin
            if (!m_busy) begin
                if (bus.i_valid || bus.d_valid) begin
                    if (bus.i_valid && bus.d_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                        m_d = m_armed ? !m_last_d : (DF != 0);
                        m_armed = 1;
`else
                        m_d = (DF != 0);
`endif
                    end else begin
                        m_d = bus.d_valid;
                    end
                    m_last_d = m_d;
                    m_busy   = 1;
                    m_addr   = m_d ? bus.d_addr  : bus.i_addr;
                    m_wdata  = m_d ? bus.d_wdata : 32'h0;
                    m_wstrb  = m_d ? bus.d_wstrb : 4'h0;
                end
            end else if (bus.mem_ready) begin
                m_busy = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                cmp("mem_valid", bus.mem_valid, m_busy);
                cmp("mem_addr",  bus.mem_addr,  m_addr);
                cmp("mem_wdata", bus.mem_wdata, m_wdata);
                cmp("mem_wstrb", bus.mem_wstrb, m_wstrb);
                cmp("i_ready", bus.i_ready, resetn && m_busy && !m_d && bus.mem_ready);
                cmp("d_ready", bus.d_ready, resetn && m_busy &&  m_d && bus.mem_ready);
                cmp("i_rdata", bus.i_rdata, bus.mem_rdata);
                cmp("d_rdata", bus.d_rdata, bus.mem_rdata);
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pulse(input bit is_d, input int target, input int budget);
        int n = 0;
        while (((is_d ? d_pulses : i_pulses) < target) && n < budget) begin
            step(1);
            n++;
        end
        cmp(is_d ? "d_ready_timeout" : "i_ready_timeout",
            32'((is_d ? d_pulses : i_pulses) >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int hi, unstable;
        bit exp_order [8];
        resetn = 1'b0;
        bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        step(2);
        i_left = 1;
        bus.i_addr = 32'h10;
        step(1);
        cmp("rst_mem_valid", bus.mem_valid, 0);
        cmp("rst_mem_addr",  bus.mem_addr,  0);
        cmp("rst_mem_wdata", bus.mem_wdata, 0);
        cmp("rst_mem_wstrb", bus.mem_wstrb, 0);
        cmp("rst_ready",     {bus.i_ready, bus.d_ready}, 0);

        // single instruction read, first edge after reset release
        resetn = 1'b1;
        step(1);
        cmp("ird_mem_valid", bus.mem_valid, 1);
        cmp("ird_mem_addr",  bus.mem_addr,  32'h10);
        cmp("ird_mem_wstrb", bus.mem_wstrb, 0);
        cmp("ird_early_rdy", bus.i_ready,   0);
        step(1);
        cmp("ird_i_ready",   bus.i_ready,   1);
        cmp("ird_i_rdata",   bus.i_rdata,   32'h1234_5678);
        step(1);
        cmp("ird_gap",       bus.mem_valid, 0);

        // mem_ready while idle is ignored
        force_ready = 1;
        step(3);
        cmp("idle_rdy_i", i_pulses, 1);
        cmp("idle_rdy_d", d_pulses, 0);
        force_ready = 0;
        step(1);

        // data write then read-back
        bus.d_addr = 32'h20; bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
        d_left = 1;
        wait_pulse(1, 1, 20);
        cmp("wr_wstrb", d_wstrb_cap, 4'hF);
        cmp("wr_wdata", d_wdata_cap, 32'hDEAD_BEEF);
        bus.d_wdata = '0; bus.d_wstrb = '0;
        d_left = 1;
        wait_pulse(1, 2, 20);
        cmp("rd_back", d_rdata_cap, 32'hDEAD_BEEF);
        step(2);

        // requester drops valid while granted
        mem_wait = 3;
        bus.d_addr = 32'h30;
        d_auto = 0; d_manual = 1;
        step(2);
        d_manual = 0;
        wait_pulse(1, 3, 20);
        step(3);
        cmp("drop_one_pulse", d_pulses, 3);
        d_auto = 1;

        // memory stall of 5 cycles
        mem_wait = 5;
        bus.i_addr = 32'h44;
        i_left = 1;
        hi = 0; unstable = 0;
        for (int n = 0; n < 30; n++) begin
            step(1);
            if (bus.mem_valid === 1'b1) begin
                hi++;
                if (bus.mem_addr !== 32'h44) unstable++;
            end
            if (i_pulses >= 2 && bus.mem_valid !== 1'b1) break;
        end
        cmp("stall_valid_cycles", hi, 6);
        cmp("stall_addr_stable", unstable, 0);
        cmp("stall_one_pulse", i_pulses, 2);

        // reset while BUSY_D with mem_ready already high
        mem_wait = 0;
        bus.d_addr = 32'h50;
        d_left = 1;
        @(negedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        d_left = 0;
        @(negedge clk);
        #1;
        cmp("rstbusy_d_ready", bus.d_ready, 0);
        cmp("rstbusy_still_valid", bus.mem_valid, 1);
        step(1);
        cmp("rstbusy_mem_valid", bus.mem_valid, 0);
        cmp("rstbusy_mem_addr",  bus.mem_addr,  0);
        cmp("rstbusy_mem_wstrb", bus.mem_wstrb, 0);
        resetn = 1'b1;
        mem_wait = 1;
        bus.i_addr = 32'h10;
        i_left = 1;
        wait_pulse(0, 3, 20);
        cmp("after_rst_rdata", i_rdata_cap, 32'h1234_5678);
        cmp("after_rst_no_d",  d_pulses, 3);
        step(2);

        // tie: 4 back-to-back requests on each port after a fresh reset
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        glog.delete();
        bus.i_addr = 32'h100; bus.d_addr = 32'h200;
        i_left = 4; d_left = 4;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif
        wait_pulse(0, 7, 80);
        wait_pulse(1, 7, 80);
        cmp("tie_count", glog.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < glog.size()) cmp($sformatf("tie_order_%0d", k), glog[k], exp_order[k]);
        end
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter DATA_FIRST, default 1: tie-break winner; 1 = data port, 0 = instruction port.
REQ-002 Clock and reset: the block SHALL use clock clk and reset resetn, which is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  synchronous active-low reset.
REQ-005 i_valid  input  1  instruction-port request.
REQ-006 i_ready  output  1  instruction-port completion strobe.
REQ-007 i_addr  input  32  instruction-port byte address.
REQ-008 i_rdata  output  32  instruction-port read data.
REQ-009 d_valid  input  1  data-port request.
REQ-010 d_ready  output  1  data-port completion strobe.
REQ-011 d_addr  input  32  data-port byte address.
REQ-012 d_rdata  output  32  data-port read data.
REQ-013 d_wdata  input  32  data-port write data.
REQ-014 d_wstrb  input  4  data-port byte strobes; 0000 = read.
REQ-015 mem_valid  output  1  memory request.
REQ-016 mem_ready  input  1  memory completion strobe.
REQ-017 mem_addr  output  32  memory address.
REQ-018 mem_rdata  input  32  memory read data.
REQ-019 mem_wdata  output  32  memory write data.
REQ-020 mem_wstrb  output  4  memory byte strobes.

Function
REQ-021 FSM states: IDLE, BUSY_I, BUSY_D. mem_valid = 1 exactly when state != IDLE.
REQ-022 In IDLE, if exactly one of i_valid/d_valid is high, the FSM SHALL move to the matching BUSY state on the next edge.
REQ-023 In IDLE, if both are high, the winner follows REQ-036/REQ-037.
REQ-024 On grant, the block SHALL latch addr, wdata and wstrb into the mem_* registers. Instruction grants latch wdata = 0 and wstrb = 0000.
REQ-025 mem_addr, mem_wdata and mem_wstrb SHALL be held stable for the whole BUSY state.
REQ-026 In BUSY_x with mem_ready = 1, the block SHALL assert x_ready combinationally in that same cycle and return to IDLE on the next edge.
REQ-027 In BUSY_x with mem_ready = 0, the FSM SHALL stay in BUSY_x indefinitely; there is no timeout.
REQ-028 i_rdata and d_rdata SHALL both be driven combinationally from mem_rdata.
REQ-029 Latency: request sampled in IDLE at cycle n -> mem_valid high at n+1 -> x_ready at n+1+k, where k >= 1 is the number of memory wait cycles. For a 1-cycle memory: ready at n+2, IDLE at n+3, minimum 3 cycles per transaction.
REQ-030 mem_valid SHALL be low for at least one cycle between consecutive transactions.
REQ-031 i_ready and d_ready SHALL never both be high; x_ready SHALL never assert outside BUSY_x.
REQ-032 A requester dropping valid while it is granted SHALL NOT abort the transaction; it completes and x_ready is still pulsed.
REQ-033 mem_ready arriving while in IDLE SHALL be ignored.

Reset
REQ-034 resetn low at any clock edge, including mid-transaction, SHALL force state IDLE. It SHALL also force mem_valid = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0000 and last-grant = instruction port. i_ready and d_ready read 0 during reset.
REQ-035 The first request SHALL be accepted at the first edge after resetn returns high.

Configuration
REQ-036 With ARB_ROUND_ROBIN_EN defined, ties SHALL go to the port not served by the most recent grant. Last-grant is a 1-bit register updated at each grant. The first tie after reset goes to the port selected by DATA_FIRST.
REQ-037 Without ARB_ROUND_ROBIN_EN, ties SHALL always go to the DATA_FIRST port (fixed priority). The last-grant register is not implemented.

Verification
REQ-038 Single instruction read: i_valid=1, i_addr=0x0000_0010, 1-cycle memory -> mem_valid at n+1 with mem_addr=0x10 and mem_wstrb=0000; i_ready at n+2; i_rdata = memory word at 0x10.
REQ-039 Data write: d_addr=0x20, d_wdata=0xDEADBEEF, d_wstrb=1111 -> mem_wstrb=1111 and mem_wdata=0xDEADBEEF; d_ready pulsed once. A following read of 0x20 returns 0xDEADBEEF.
REQ-040 Tie with DATA_FIRST=1 and 4 back-to-back requests on both ports -> data granted first. Round-robin build: grant order D,I,D,I. Fixed build: data port is served every time while d_valid stays high.
REQ-041 Memory stall: mem_ready held 0 for 5 cycles -> mem_valid and mem_addr stable for 6 cycles; exactly one x_ready pulse.
REQ-042 resetn pulsed low while in BUSY_D -> next cycle mem_valid = 0 and no d_ready is generated. A new i_valid after reset is served normally.
